// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
// Shares one SRAM-like memory port between an instruction-fetch master and a
// data (load/store) master. Data has fixed priority; a request that has been
// presented but not yet accepted is locked so it cannot be preempted. A small
// owner FIFO records which master issued each accepted request so the
// in-order responses are routed back to the correct master.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   inst_* / data_*  (in)           master request channels (req, wr, size,
//                                   wstrb, addr, wdata)
//   inst_addr_ok / data_addr_ok     address handshake done for that master
//   inst_data_ok / data_data_ok     response for that master's oldest request
//   inst_rdata / data_rdata         pass-through of mem_rdata
//   mem_req .. mem_wdata  (out)     slave request channel
//   mem_addr_ok, mem_data_ok,
//   mem_rdata        (in)           slave handshake / response
module sram_bus_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;   // 0 = inst, 1 = data
    logic [DEPTH-1:0]   fifo_q, fifo_d;     // owner id per outstanding request
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic full;
    logic sel;      // candidate owner when idle
    logic gid;      // id actually presented on mem_*
    logic push;
    logic pop;
    logic head;

    // Fullness depends only on the registered count, so mem_data_ok never
    // reaches mem_req combinationally.
    assign full = (cnt_q == FULL_CNT);
    assign head = fifo_q[rptr_q];

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        fifo_d     = fifo_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_size   = 2'd0;
        mem_wstrb  = 4'd0;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;

        sel = data_req;     // data wins whenever it is requesting
        gid = sel;

        if (state_q == LOCK) begin
            // Presented request is held until accepted; no preemption.
            gid     = owner_q;
            mem_req = 1'b1;
        end else begin
            mem_req = !full && (inst_req || data_req);
        end
        if (reset) begin
            mem_req = 1'b0;
        end

        if (mem_req) begin
            if (gid) begin
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_wr    = inst_wr;
                mem_size  = inst_size;
                mem_wstrb = inst_wstrb;
                mem_addr  = inst_addr;
                mem_wdata = inst_wdata;
            end
        end

        push = mem_req && mem_addr_ok;
        // A response with nothing outstanding is a protocol error: dropped.
        pop  = mem_data_ok && (cnt_q != '0) && !reset;

        inst_addr_ok = push && !gid;
        data_addr_ok = push &&  gid;
        inst_data_ok = pop  && !head;
        data_data_ok = pop  &&  head;

        if (push) begin
            fifo_d[wptr_q] = gid;
            wptr_d         = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

        case (state_q)
            IDLE: begin
                if (mem_req && !mem_addr_ok) begin
                    owner_d = sel;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (mem_addr_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the owner storage is not reset; an entry is only ever read after
    // it has been written, because count gates every pop.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed testbench for sram_bus_arbiter (DEPTH = 2). The bench plays the
// memory slave by driving mem_addr_ok / mem_data_ok / mem_rdata directly.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 0; mem_data_ok = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " mem_req"},      32'(mem_req),      32'd0);
        check({tag, " mem_wr"},       32'(mem_wr),       32'd0);
        check({tag, " mem_size"},     32'(mem_size),     32'd0);
        check({tag, " mem_wstrb"},    32'(mem_wstrb),    32'd0);
        check({tag, " mem_addr"},     mem_addr,          32'd0);
        check({tag, " mem_wdata"},    mem_wdata,         32'd0);
        check({tag, " inst_addr_ok"}, 32'(inst_addr_ok), 32'd0);
        check({tag, " data_addr_ok"}, 32'(data_addr_ok), 32'd0);
        check({tag, " inst_data_ok"}, 32'(inst_data_ok), 32'd0);
        check({tag, " data_data_ok"}, 32'(data_data_ok), 32'd0);
        check({tag, " inst_rdata"},   inst_rdata,        mem_rdata);
        check({tag, " data_rdata"},   data_rdata,        mem_rdata);
    endtask

    initial begin
        idle_inputs();
        mem_rdata = 32'hdeadbeef;
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // ---------------- Reset state ----------------
        settle();
        check_reset_outputs("reset");
        mem_data_ok = 1;
        settle();
        check("reset stray inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("reset stray data_data_ok", 32'(data_data_ok), 32'd0);
        tick();
        mem_data_ok = 0;
        reset = 0;
        settle();
        check_reset_outputs("post-reset");
        tick();

        // ---------------- Single inst read ----------------
        inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
        settle();
        check("single mem_req", 32'(mem_req), 32'd1);
        check("single mem_addr", mem_addr, 32'h1c000000);
        check("single mem_size", 32'(mem_size), 32'd2);
        check("single inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        check("single data_addr_ok", 32'(data_addr_ok), 32'd0);
        check("single inst_data_ok c0", 32'(inst_data_ok), 32'd0);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        settle();
        check("single inst_data_ok c1", 32'(inst_data_ok), 32'd0);
        check("single data_data_ok c1", 32'(data_data_ok), 32'd0);
        check("single mem_req c1", 32'(mem_req), 32'd0);
        tick();
        mem_data_ok = 1; mem_rdata = 32'h02800c0c;
        settle();
        check("single inst_data_ok c2", 32'(inst_data_ok), 32'd1);
        check("single inst_rdata c2", inst_rdata, 32'h02800c0c);
        check("single data_data_ok c2", 32'(data_data_ok), 32'd0);
        tick();
        mem_data_ok = 0;

        // ---------------- Priority ----------------
        inst_req = 1; inst_addr = 32'h1c000004;
        data_req = 1; data_wr = 0; data_addr = 32'h1c008004;
        mem_addr_ok = 1;
        settle();
        check("prio data_addr_ok c0", 32'(data_addr_ok), 32'd1);
        check("prio inst_addr_ok c0", 32'(inst_addr_ok), 32'd0);
        check("prio mem_addr c0", mem_addr, 32'h1c008004);
        tick();
        data_req = 0;
        settle();
        check("prio inst_addr_ok c1", 32'(inst_addr_ok), 32'd1);
        check("prio data_addr_ok c1", 32'(data_addr_ok), 32'd0);
        check("prio mem_addr c1", mem_addr, 32'h1c000004);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        mem_data_ok = 1; mem_rdata = 32'h11111111;
        settle();
        check("prio resp1 data_data_ok", 32'(data_data_ok), 32'd1);
        check("prio resp1 inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("prio resp1 data_rdata", data_rdata, 32'h11111111);
        tick();
        mem_rdata = 32'h22222222;
        settle();
        check("prio resp2 inst_data_ok", 32'(inst_data_ok), 32'd1);
        check("prio resp2 data_data_ok", 32'(data_data_ok), 32'd0);
        tick();
        mem_data_ok = 0;

        // ---------------- Lock ----------------
        inst_req = 1; inst_addr = 32'h1c000010;
        settle();
        check("lock mem_addr c0", mem_addr, 32'h1c000010);
        check("lock inst_addr_ok c0", 32'(inst_addr_ok), 32'd0);
        tick();
        data_req = 1; data_wr = 1; data_addr = 32'h1c008010;
        data_wdata = 32'haabbccdd; data_wstrb = 4'hf;
        settle();
        check("lock mem_addr c1", mem_addr, 32'h1c000010);
        check("lock mem_wr c1", 32'(mem_wr), 32'd0);
        tick();
        settle();
        check("lock mem_addr c2", mem_addr, 32'h1c000010);
        tick();
        mem_addr_ok = 1;
        settle();
        check("lock mem_addr c3", mem_addr, 32'h1c000010);
        check("lock inst_addr_ok c3", 32'(inst_addr_ok), 32'd1);
        check("lock data_addr_ok c3", 32'(data_addr_ok), 32'd0);
        tick();
        inst_req = 0;
        settle();
        check("lock data_addr_ok c4", 32'(data_addr_ok), 32'd1);
        check("lock mem_addr c4", mem_addr, 32'h1c008010);
        check("lock mem_wr c4", 32'(mem_wr), 32'd1);
        check("lock mem_wdata c4", mem_wdata, 32'haabbccdd);
        check("lock mem_wstrb c4", 32'(mem_wstrb), 32'hf);
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        settle();
        check("lock resp1 inst_data_ok", 32'(inst_data_ok), 32'd1);
        tick();
        settle();
        check("lock resp2 data_data_ok", 32'(data_data_ok), 32'd1);
        check("lock resp2 inst_data_ok", 32'(inst_data_ok), 32'd0);
        tick();
        mem_data_ok = 0;

        // ---------------- Full ----------------
        data_req = 1; data_wr = 1; data_addr = 32'h1c009000; mem_addr_ok = 1;
        settle();
        check("full st0 data_addr_ok", 32'(data_addr_ok), 32'd1);
        tick();
        data_addr = 32'h1c009004;
        settle();
        check("full st1 data_addr_ok", 32'(data_addr_ok), 32'd1);
        tick();
        data_addr = 32'h1c009008;
        settle();
        check("full st2 mem_req c2", 32'(mem_req), 32'd0);
        check("full st2 data_addr_ok c2", 32'(data_addr_ok), 32'd0);
        tick();
        mem_data_ok = 1;
        settle();
        check("full pop mem_req c3", 32'(mem_req), 32'd0);
        check("full pop data_addr_ok c3", 32'(data_addr_ok), 32'd0);
        check("full pop data_data_ok c3", 32'(data_data_ok), 32'd1);
        tick();
        mem_data_ok = 0;
        settle();
        check("full st2 mem_req c4", 32'(mem_req), 32'd1);
        check("full st2 data_addr_ok c4", 32'(data_addr_ok), 32'd1);
        check("full st2 mem_addr c4", mem_addr, 32'h1c009008);
        tick();
        data_req = 0; data_wr = 0; mem_addr_ok = 0; mem_data_ok = 1;
        settle();
        check("full drain1 data_data_ok", 32'(data_data_ok), 32'd1);
        tick();
        settle();
        check("full drain2 data_data_ok", 32'(data_data_ok), 32'd1);
        tick();
        mem_data_ok = 0;
        settle();
        check("full drained mem_req", 32'(mem_req), 32'd0);

        // ---------------- Wrap with simultaneous push/pop ----------------
        // Request k is inst when k is even, data when odd; the response to
        // request k-1 returns in the same cycle request k is accepted.
        for (int k = 0; k <= 10; k++) begin
            inst_req    = (k < 10) && (k % 2 == 0);
            data_req    = (k < 10) && (k % 2 == 1);
            inst_addr   = 32'h1c000100 + 32'(k * 4);
            data_addr   = 32'h1c008100 + 32'(k * 4);
            mem_addr_ok = (k < 10);
            mem_data_ok = (k > 0);
            mem_rdata   = 32'h0000a000 + 32'(k);
            settle();
            if (k < 10) begin
                check($sformatf("wrap%0d mem_req", k), 32'(mem_req), 32'd1);
                check($sformatf("wrap%0d inst_addr_ok", k), 32'(inst_addr_ok),
                      (k % 2 == 0) ? 32'd1 : 32'd0);
                check($sformatf("wrap%0d data_addr_ok", k), 32'(data_addr_ok),
                      (k % 2 == 1) ? 32'd1 : 32'd0);
            end
            if (k > 0) begin
                check($sformatf("wrap%0d inst_data_ok", k), 32'(inst_data_ok),
                      ((k - 1) % 2 == 0) ? 32'd1 : 32'd0);
                check($sformatf("wrap%0d data_data_ok", k), 32'(data_data_ok),
                      ((k - 1) % 2 == 1) ? 32'd1 : 32'd0);
            end
            tick();
        end
        idle_inputs();
        mem_data_ok = 1;
        settle();
        check("wrap empty inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("wrap empty data_data_ok", 32'(data_data_ok), 32'd0);
        tick();
        mem_data_ok = 0;

        // ---------------- Reset with outstanding requests ----------------
        data_req = 1; data_addr = 32'h1c008200; mem_addr_ok = 1;
        tick();
        data_req = 0; inst_req = 1; inst_addr = 32'h1c000200;
        tick();
        idle_inputs();
        reset = 1;
        settle();
        check_reset_outputs("rst-mid");
        tick();
        mem_data_ok = 1;
        settle();
        check("rst-mid stray inst_data_ok", 32'(inst_data_ok), 32'd0);
        check("rst-mid stray data_data_ok", 32'(data_data_ok), 32'd0);
        tick();
        reset = 0;
        for (int k = 0; k < 2; k++) begin
            settle();
            check($sformatf("post-rst stray%0d inst_data_ok", k), 32'(inst_data_ok), 32'd0);
            check($sformatf("post-rst stray%0d data_data_ok", k), 32'(data_data_ok), 32'd0);
            tick();
        end
        mem_data_ok = 0;

        // Normal traffic resumes after the reset.
        inst_req = 1; inst_addr = 32'h1c000300; mem_addr_ok = 1;
        settle();
        check("resume inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        tick();
        idle_inputs();
        mem_data_ok = 1; mem_rdata = 32'h12345678;
        settle();
        check("resume inst_data_ok", 32'(inst_data_ok), 32'd1);
        check("resume inst_rdata", inst_rdata, 32'h12345678);
        tick();
        mem_data_ok = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
